// File: rtl/sr_ctrl_pkg.sv
// Shared state encoding and default timing for the SR latch bank controller.
// The helper function sizes the phase counter to the longest phase.
package sr_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ENABLE = 3'd2,
      HOLD   = 3'd3,
      CHECK  = 3'd4
   } stateT;

   localparam int SETUP_CYC_D = 1;
   localparam int EN_CYC_D    = 2;
   localparam int HOLD_CYC_D  = 1;

   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sr_latch_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer only moves when the caller
// commits to a grant via the advance strobe.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] winner
);

   logic favorOne;

   always_comb begin
      winner = 2'b00;
      case (req)
         2'b01:   winner = 2'b01;
         2'b10:   winner = 2'b10;
         2'b11:   winner = favorOne ? 2'b10 : 2'b01;
         default: winner = 2'b00;
      endcase
   end

   // After serving requester 0, requester 1 is preferred on the next tie, and vice versa.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         favorOne <= 1'b0;
      else if (advance)
         favorOne <= winner[0];
   end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequences set/reset patterns into a bank of gated SR latches for two requesters:
// setup, enable pulse, hold, then readback check with a pass/fail report.
module sr_latch_ctrl
   import sr_ctrl_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int SETUP_CYC = SETUP_CYC_D,
   parameter int EN_CYC    = EN_CYC_D,
   parameter int HOLD_CYC  = HOLD_CYC_D
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] set_mask0,
   input  logic [WIDTH-1:0] set_mask1,
   input  logic [WIDTH-1:0] clr_mask0,
   input  logic [WIDTH-1:0] clr_mask1,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             err,
   output logic             busy,
   output logic             lat_en,
   output logic [WIDTH-1:0] lat_s,
   output logic [WIDTH-1:0] lat_r,
   input  logic [WIDTH-1:0] lat_q
);

   localparam int CNT_W = $clog2(maxOf3(SETUP_CYC, EN_CYC, HOLD_CYC)) + 1;

   stateT            state;
   logic [CNT_W-1:0] phaseCnt;
   logic [1:0]       winner;
   logic [1:0]       owner;
   logic [WIDTH-1:0] seReg;
   logic [WIDTH-1:0] reReg;
   logic             conflict;
   logic             arbAdvance;
   logic [WIDTH-1:0] selSet;
   logic [WIDTH-1:0] selClr;
   logic [WIDTH-1:0] selConf;
   logic             readMismatch;

   assign arbAdvance = (state == IDLE) && (req != 2'b00);

   rr_arb2 uArb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .advance (arbAdvance),
      .winner  (winner)
   );

   // Bits asked to be both set and cleared are dropped from the drive pattern and flagged.
   always_comb begin
      selSet       = winner[1] ? set_mask1 : set_mask0;
      selClr       = winner[1] ? clr_mask1 : clr_mask0;
      selConf      = selSet & selClr;
      readMismatch = |((lat_q ^ seReg) & (seReg | reReg));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         phaseCnt <= '0;
         owner    <= 2'b00;
         seReg    <= '0;
         reReg    <= '0;
         conflict <= 1'b0;
         gnt      <= 2'b00;
         done     <= 2'b00;
         err      <= 1'b0;
         busy     <= 1'b0;
         lat_en   <= 1'b0;
         lat_s    <= '0;
         lat_r    <= '0;
      end else begin
         gnt  <= 2'b00;
         done <= 2'b00;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (arbAdvance) begin
                  state    <= SETUP;
                  gnt      <= winner;
                  owner    <= winner;
                  seReg    <= selSet & ~selConf;
                  reReg    <= selClr & ~selConf;
                  lat_s    <= selSet & ~selConf;
                  lat_r    <= selClr & ~selConf;
                  conflict <= |selConf;
                  busy     <= 1'b1;
                  phaseCnt <= CNT_W'(SETUP_CYC - 1);
               end
            end
            SETUP: begin
               if (phaseCnt == '0) begin
                  state    <= ENABLE;
                  lat_en   <= 1'b1;
                  phaseCnt <= CNT_W'(EN_CYC - 1);
               end else begin
                  phaseCnt <= phaseCnt - CNT_W'(1);
               end
            end
            ENABLE: begin
               if (phaseCnt == '0) begin
                  state    <= HOLD;
                  lat_en   <= 1'b0;
                  phaseCnt <= CNT_W'(HOLD_CYC - 1);
               end else begin
                  phaseCnt <= phaseCnt - CNT_W'(1);
               end
            end
            HOLD: begin
               if (phaseCnt == '0) begin
                  state <= CHECK;
                  lat_s <= '0;
                  lat_r <= '0;
               end else begin
                  phaseCnt <= phaseCnt - CNT_W'(1);
               end
            end
            CHECK: begin
               state <= IDLE;
               done  <= owner;
               err   <= readMismatch | conflict;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: behavioural latch banks, a table of directed operations,
// reset and alternate-timing sequences, and randomized operations against a model.
module tb_sr_latch_ctrl;

   typedef struct {
      logic [1:0] req;
      logic [7:0] set0, clr0, set1, clr1, stuck;
      logic [1:0] expWin;
      logic       expErr;
      logic [7:0] expQ;
   } vecT;

   logic       clk;
   logic       rst_n;
   logic       sel;
   logic [1:0] reqV;
   logic [7:0] set0, clr0, set1, clr1, stuck;
   logic [1:0] reqA, reqB;
   logic [1:0] gntA, gntB, doneA, doneB;
   logic       errA, errB, busyA, busyB, latEnA, latEnB;
   logic [7:0] latSA, latSB, latRA, latRB, latQA, latQB;
   logic [7:0] bankA = 8'h00;
   logic [7:0] bankB = 8'h00;
   logic [1:0] obsGnt, obsDone;
   logic       obsErr, obsBusy, obsEn;
   logic [7:0] obsS, obsR, obsQ;
   int         errors, checks;
   int         favor [2];
   logic [7:0] modelBank [2];
   vecT        vecs [7];

   assign reqA = sel ? 2'b00 : reqV;
   assign reqB = sel ? reqV : 2'b00;
   assign latQA = bankA & ~stuck;
   assign latQB = bankB;
   assign obsGnt  = sel ? gntB   : gntA;
   assign obsDone = sel ? doneB  : doneA;
   assign obsErr  = sel ? errB   : errA;
   assign obsBusy = sel ? busyB  : busyA;
   assign obsEn   = sel ? latEnB : latEnA;
   assign obsS    = sel ? latSB  : latSA;
   assign obsR    = sel ? latRB  : latRA;
   assign obsQ    = sel ? latQB  : latQA;

   sr_latch_ctrl uDutA (
      .clk(clk), .rst_n(rst_n), .req(reqA),
      .set_mask0(set0), .set_mask1(set1), .clr_mask0(clr0), .clr_mask1(clr1),
      .gnt(gntA), .done(doneA), .err(errA), .busy(busyA),
      .lat_en(latEnA), .lat_s(latSA), .lat_r(latRA), .lat_q(latQA)
   );

   sr_latch_ctrl #(.WIDTH(8), .SETUP_CYC(3), .EN_CYC(1), .HOLD_CYC(2)) uDutB (
      .clk(clk), .rst_n(rst_n), .req(reqB),
      .set_mask0(set0), .set_mask1(set1), .clr_mask0(clr0), .clr_mask1(clr1),
      .gnt(gntB), .done(doneB), .err(errB), .busy(busyB),
      .lat_en(latEnB), .lat_s(latSB), .lat_r(latRB), .lat_q(latQB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Gated NAND SR latch bank: transparent while enabled, S wins to 1, R wins to 0.
   always @(latEnA or latSA or latRA)
      if (latEnA === 1'b1) bankA = (bankA | latSA) & ~latRA;
   always @(latEnB or latSB or latRB)
      if (latEnB === 1'b1) bankB = (bankB | latSB) & ~latRB;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] r, input logic [7:0] s0, input logic [7:0] c0,
                                input logic [7:0] s1, input logic [7:0] c1, input logic [7:0] st);
      reqV  = reqV | r;
      set0  = s0;
      clr0  = c0;
      set1  = s1;
      clr1  = c1;
      stuck = st;
   endtask

   // Reference: arbitration by round-robin preference, then the bank's new contents and the verdict.
   task automatic modelStep(input int d, output logic [1:0] w, output logic er, output logic [7:0] q);
      logic [7:0] s, c, se, re;
      if (reqV == 2'b11) w = (favor[d] == 0) ? 2'b01 : 2'b10;
      else               w = reqV;
      favor[d] = (w == 2'b01) ? 1 : 0;
      s  = w[1] ? set1 : set0;
      c  = w[1] ? clr1 : clr0;
      se = s & ~c;
      re = c & ~s;
      modelBank[d] = (modelBank[d] | se) & ~re;
      q  = modelBank[d] & ~((d == 0) ? stuck : 8'h00);
      er = ((s & c) != 8'h00) || (((q ^ se) & (se | re)) != 8'h00);
   endtask

   task automatic runOp(input int s, input int e, input int h,
                        input logic [1:0] expWin, input logic expErr, input logic [7:0] expQ);
      logic [7:0] selS, selC, se, re;
      int p;
      selS = expWin[1] ? set1 : set0;
      selC = expWin[1] ? clr1 : clr0;
      se   = selS & ~selC;
      re   = selC & ~selS;
      p    = s + e + h + 2;
      @(posedge clk);
      for (int c = 1; c <= p; c++) begin
         @(negedge clk);
         checkOutput("gnt", 32'(obsGnt), (c == 1) ? 32'(expWin) : 32'd0);
         checkOutput("lat_en", 32'(obsEn), 32'(c > s && c <= s + e));
         checkOutput("lat_s", 32'(obsS), (c <= s + e + h) ? 32'(se) : 32'd0);
         checkOutput("lat_r", 32'(obsR), (c <= s + e + h) ? 32'(re) : 32'd0);
         checkOutput("sr_overlap", 32'(obsS & obsR), 32'd0);
         checkOutput("busy", 32'(obsBusy), 32'(c < p));
         checkOutput("done", 32'(obsDone), (c == p) ? 32'(expWin) : 32'd0);
         if (c == p) begin
            checkOutput("err", 32'(obsErr), 32'(expErr));
            checkOutput("lat_q", 32'(obsQ), 32'(expQ));
         end
         if (c == 1) reqV = reqV & ~expWin;
         if (c == 2) begin
            set0 = 8'($urandom);
            clr0 = 8'($urandom);
            set1 = 8'($urandom);
            clr1 = 8'($urandom);
         end
      end
   endtask

   initial begin
      logic [1:0] w;
      logic       er;
      logic [7:0] q;

      vecs[0] = '{req:2'b11, set0:8'h0F, clr0:8'hF0, set1:8'h3C, clr1:8'h00, stuck:8'h00, expWin:2'b01, expErr:1'b0, expQ:8'h0F};
      vecs[1] = '{req:2'b00, set0:8'h00, clr0:8'h00, set1:8'h3C, clr1:8'h00, stuck:8'h00, expWin:2'b10, expErr:1'b0, expQ:8'h3F};
      vecs[2] = '{req:2'b11, set0:8'h81, clr0:8'h01, set1:8'h00, clr1:8'hFF, stuck:8'h00, expWin:2'b01, expErr:1'b1, expQ:8'hBF};
      vecs[3] = '{req:2'b00, set0:8'h00, clr0:8'h00, set1:8'h00, clr1:8'hFF, stuck:8'h00, expWin:2'b10, expErr:1'b0, expQ:8'h00};
      vecs[4] = '{req:2'b01, set0:8'h08, clr0:8'h00, set1:8'h00, clr1:8'h00, stuck:8'h08, expWin:2'b01, expErr:1'b1, expQ:8'h00};
      vecs[5] = '{req:2'b10, set0:8'h00, clr0:8'h00, set1:8'h00, clr1:8'h00, stuck:8'h00, expWin:2'b10, expErr:1'b0, expQ:8'h08};
      vecs[6] = '{req:2'b01, set0:8'hFF, clr0:8'hFF, set1:8'h00, clr1:8'h00, stuck:8'h00, expWin:2'b01, expErr:1'b1, expQ:8'h08};

      errors = 0;
      checks = 0;
      sel    = 1'b0;
      reqV   = 2'b00;
      set0 = 8'h00; clr0 = 8'h00; set1 = 8'h00; clr1 = 8'h00; stuck = 8'h00;
      favor[0] = 0; favor[1] = 0;
      modelBank[0] = 8'h00; modelBank[1] = 8'h00;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_gnt", 32'(gntA), 32'd0);
      checkOutput("reset_done", 32'(doneA), 32'd0);
      checkOutput("reset_busy", 32'(busyA), 32'd0);
      checkOutput("reset_lat_en", 32'(latEnA), 32'd0);
      checkOutput("reset_lat_sr", 32'({latSA, latRA}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].req, vecs[i].set0, vecs[i].clr0, vecs[i].set1, vecs[i].clr1, vecs[i].stuck);
         modelStep(0, w, er, q);
         runOp(1, 2, 1, vecs[i].expWin, vecs[i].expErr, vecs[i].expQ);
      end
      stuck = 8'h00;

      // Asynchronous reset while the enable pulse is high.
      applyStimulus(2'b01, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
      @(posedge clk);
      @(negedge clk);
      reqV = 2'b00;
      @(negedge clk);
      checkOutput("en_before_reset", 32'(latEnA), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("async_lat_en", 32'(latEnA), 32'd0);
      checkOutput("async_lat_s", 32'(latSA), 32'd0);
      checkOutput("async_lat_r", 32'(latRA), 32'd0);
      checkOutput("async_busy", 32'(busyA), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      favor[0] = 0;
      modelBank[0] = 8'hAA;
      applyStimulus(2'b11, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00);
      modelStep(0, w, er, q);
      runOp(1, 2, 1, 2'b01, er, q);
      modelStep(0, w, er, q);
      runOp(1, 2, 1, 2'b10, er, q);

      // Alternate timing instance: setup 3, enable 1, hold 2.
      sel = 1'b1;
      applyStimulus(2'b01, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00);
      runOp(3, 1, 2, 2'b01, 1'b0, 8'h0F);
      applyStimulus(2'b10, 8'h00, 8'h00, 8'h81, 8'h01, 8'h00);
      runOp(3, 1, 2, 2'b10, 1'b1, 8'h8F);
      @(negedge clk);
      sel = 1'b0;

      for (int i = 0; i < 20; i++) begin
         applyStimulus(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom),
                       8'($urandom), 8'($urandom), 8'h00);
         modelStep(0, w, er, q);
         runOp(1, 2, 1, w, er, q);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Clocked sequencer and two-requester arbiter for a WIDTH-bit bank of gated NAND SR latches. Each accepted request produces a set/reset pattern, holds it stable, pulses the shared latch enable, and holds the pattern again. It then reads back the latch outputs and reports pass or fail to the requester. This is the only block that drives the bank's S, R and En nets; it guarantees S and R are never both high on any bit.

## Interface

Parameters:
- WIDTH, 8: number of latches in the bank.
- SETUP_CYC, 1: cycles S/R are stable before En rises; must be 1 or more.
- EN_CYC, 2: En high width in cycles; must be 1 or more.
- HOLD_CYC, 1: cycles S/R are held after En falls; must be 1 or more.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  request per requester; held high until the matching gnt.
- set_mask0, set_mask1  in  WIDTH each  bits to set, for requester 0 and requester 1.
- clr_mask0, clr_mask1  in  WIDTH each  bits to clear, for requester 0 and requester 1.
- gnt  out  2  one-cycle grant pulse, one-hot.
- done  out  2  one-cycle completion pulse to the granted requester.
- err  out  1  valid only while done is nonzero: readback mismatch or mask conflict.
- busy  out  1  high in every state except IDLE.
- lat_en  out  1  bank enable.
- lat_s  out  WIDTH  bank set lines.
- lat_r  out  WIDTH  bank reset lines.
- lat_q  in  WIDTH  bank Q outputs.

## Operation

- FSM states: IDLE, SETUP, ENABLE, HOLD, CHECK.
- IDLE with req nonzero goes to SETUP. SETUP, ENABLE and HOLD each last their parameter count. CHECK always goes to IDLE.
- Arbitration happens at the edge that leaves IDLE:
  - If one req is high, that requester wins.
  - If both are high, the requester not served last wins (round-robin). The pointer favours requester 0 after reset.
- The winner's masks are captured at the same edge. Mask changes after that edge are ignored.
- Conflict bits are those with set and clr both high (c = set & clr). Effective masks are se = set & ~c and re = clr & ~c.
- lat_s = se and lat_r = re during SETUP, ENABLE and HOLD; both are 0 in IDLE and CHECK. lat_s & lat_r is never nonzero.
- lat_en is 1 only in ENABLE.
- Readback is sampled in CHECK. There is a mismatch if any se bit has lat_q = 0 or any re bit has lat_q = 1. Bits outside se|re are not compared.
- err = mismatch OR (c != 0).
- The controller never resets or drives the latches outside a request; latch contents survive controller reset.

## Timing

- Reset, asynchronous and immediate (including mid-operation):
  - state = IDLE; round-robin pointer favours requester 0.
  - gnt, done, err, busy, lat_en, lat_s, lat_r all 0.
  - En is dropped with S/R in the same instant. A partially written bank is acceptable.
- All outputs are registered; no combinational path from req or lat_q to any output.
- Let edge 0 be the edge where IDLE samples req:
  - gnt is high in cycle 1, the first SETUP cycle.
  - ENABLE occupies cycles SETUP_CYC+1 .. SETUP_CYC+EN_CYC.
  - HOLD follows for HOLD_CYC cycles, then CHECK is one cycle.
  - done and err are high in cycle SETUP_CYC+EN_CYC+HOLD_CYC+2, with the FSM back in IDLE.
  - With default parameters: gnt in cycle 1, En in cycles 2–3, CHECK in cycle 5, done in cycle 6.
- A new request may be accepted at the edge ending the done cycle, so back-to-back operations have a period of SETUP_CYC+EN_CYC+HOLD_CYC+2.
- Requester rule: drop req in the cycle after gnt. A req still high when IDLE next samples is treated as a new request.
- busy rises in cycle 1 and falls in the done cycle.

## Structure

- Package sr_ctrl_pkg holds:
  - the state encoding (3-bit, five states);
  - default timing constants SETUP_CYC_D, EN_CYC_D and HOLD_CYC_D.
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req[1:0], an advance strobe, clk, rst_n.
  - Output: one-hot winner.
  - The pointer updates only on the advance strobe.
- Phase counter width: clog2 of the maximum of the three cycle parameters, plus 1.

## Test plan

- Reset, then req0 with set=0x0F and clr=0xF0 on a behavioral latch bank → gnt=01 in cycle 1; lat_en high in cycles 2–3; done=01 with err=0 in cycle 6; lat_q=0x0F.
- req=11 held from reset → requester 0 is served first. req1 is still pending, so it is granted at the edge ending cycle 6 (gnt=10 in cycle 7). After that, the pointer favours requester 0 again.
- set=0x81, clr=0x01 → lat_s=0x80 and lat_r=0x00, never overlapping; bit 0 is unchanged; err=1 with done.
- Bank model stuck at lat_q[3]=0 with set=0x08 → err=1 with done; no retry.
- rst_n low during ENABLE → lat_en, lat_s, lat_r, busy drop to 0 without waiting for a clock edge; the next request after release is granted to requester 0 with normal timing.
- SETUP_CYC=3, EN_CYC=1, HOLD_CYC=2 → lat_en high only in cycle 4; done in cycle 8; S/R stable in cycles 1–6; assertion that lat_s & lat_r is zero in every cycle.
